// File: rtl/tt_gpio_cfg_seq_if.sv
// ============================================================================
//  Module      : tt_gpio_cfg_seq_if
//  Description : Handshake bundle between the tt_top control logic (master)
//                and the GPIO pad configuration sequencer (slave).
//                  cfg_valid/cfg_ready/cfg_pad/cfg_data : staged-bank writes
//                  cfg_err                              : bad-index pulse
//                  commit/busy/done                     : bank commit control
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tt_gpio_cfg_seq_if #(
  parameter int PAD_IDX_W = 6
);
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [PAD_IDX_W-1:0] cfg_pad;
  logic [10:0]          cfg_data;
  logic                 cfg_err;
  logic                 commit;
  logic                 busy;
  logic                 done;

  modport master (
    output cfg_valid, cfg_pad, cfg_data, commit,
    input  cfg_ready, cfg_err, busy, done
  );

  modport slave (
    input  cfg_valid, cfg_pad, cfg_data, commit,
    output cfg_ready, cfg_err, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/tt_gpio_cfg_seq.sv
// ============================================================================
//  Module      : tt_gpio_cfg_seq
//  Description : Runtime GPIO pad configuration sequencer. A staged bank of
//                per-pad 11-bit words is written one pad at a time; a commit
//                copies it into the active bank that drives the pad controls.
//                Build option TT_GPIO_CFG_STAGGER_EN: when defined the commit
//                copies one pad every STAGGER_DIV cycles, otherwise the whole
//                bank is copied in a single cycle.
//  Ports       : clk, rst (async, active-high)
//                bus      - tt_gpio_cfg_seq_if.slave (write + commit handshake)
//                gpio_*   - N_PADS-wide pad controls, from active bank only
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tt_gpio_cfg_seq #(
  parameter int          N_PADS      = 44,
  parameter logic [10:0] DEFAULT_CFG = 11'h100,
  parameter int          STAGGER_DIV = 4,
  parameter int          PAD_IDX_W   = $clog2(N_PADS)
) (
  input  wire logic          clk,
  input  wire logic          rst,
  tt_gpio_cfg_seq_if.slave   bus,
  output logic [N_PADS-1:0]  gpio_inp_dis,
  output logic [N_PADS-1:0]  gpio_ib_mode_sel,
  output logic [N_PADS-1:0]  gpio_vtrip_sel,
  output logic [N_PADS-1:0]  gpio_slow_sel,
  output logic [N_PADS-1:0]  gpio_holdover,
  output logic [N_PADS-1:0]  gpio_analog_en,
  output logic [N_PADS-1:0]  gpio_analog_sel,
  output logic [N_PADS-1:0]  gpio_analog_pol,
  output logic [N_PADS-1:0]  gpio_dm0,
  output logic [N_PADS-1:0]  gpio_dm1,
  output logic [N_PADS-1:0]  gpio_dm2
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_APPLY = 1'b1
  } state_e;

  // Index range check done one bit wider so N_PADS itself is representable.
  localparam logic [PAD_IDX_W:0] c_n_pads_ext = (PAD_IDX_W + 1)'(N_PADS);

  if (STAGGER_DIV < 1) begin : g_bad_stagger_div
    $error("tt_gpio_cfg_seq: STAGGER_DIV must be at least 1");
  end

  state_e      state_q;
  logic        err_q;
  logic        done_q;
  logic [10:0] staged_q [N_PADS];
  logic [10:0] active_q [N_PADS];

  logic        wr_fire;
  logic        wr_in_range;

`ifdef TT_GPIO_CFG_STAGGER_EN
  localparam int                   c_cnt_w    = (STAGGER_DIV > 1) ? $clog2(STAGGER_DIV) : 1;
  localparam logic [c_cnt_w-1:0]   c_cnt_load = c_cnt_w'(STAGGER_DIV - 1);
  localparam logic [PAD_IDX_W-1:0] c_last_idx = PAD_IDX_W'(N_PADS - 1);

  logic [PAD_IDX_W-1:0] idx_q;
  logic [c_cnt_w-1:0]   cnt_q;
`endif

  // Writes are only taken in IDLE, so staged never changes while it is copied.
  assign wr_fire     = bus.cfg_valid && (state_q == S_IDLE);
  assign wr_in_range = ({1'b0, bus.cfg_pad} < c_n_pads_ext);

  assign bus.cfg_ready = (state_q == S_IDLE);
  assign bus.busy      = (state_q == S_APPLY);
  assign bus.cfg_err   = err_q;
  assign bus.done      = done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      for (int p = 0; p < N_PADS; p++) begin
        staged_q[p] <= DEFAULT_CFG;
        active_q[p] <= DEFAULT_CFG;
      end
`ifdef TT_GPIO_CFG_STAGGER_EN
      idx_q <= '0;
      cnt_q <= '0;
`endif
    end else begin
      err_q  <= wr_fire && !wr_in_range;
      done_q <= 1'b0;

      if (wr_fire && wr_in_range) begin
        staged_q[bus.cfg_pad] <= bus.cfg_data;
      end

      case (state_q)
        S_IDLE: begin
          if (bus.commit) begin
            state_q <= S_APPLY;
`ifdef TT_GPIO_CFG_STAGGER_EN
            idx_q   <= '0;
            cnt_q   <= '0;
`endif
          end
        end

        S_APPLY: begin
`ifdef TT_GPIO_CFG_STAGGER_EN
          // One pad per STAGGER_DIV cycles; cnt counts the gap between pads.
          if (cnt_q == '0) begin
            active_q[idx_q] <= staged_q[idx_q];
            if (idx_q == c_last_idx) begin
              state_q <= S_IDLE;
              done_q  <= 1'b1;
            end else begin
              idx_q <= idx_q + 1'b1;
              cnt_q <= c_cnt_load;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
`else
          for (int p = 0; p < N_PADS; p++) begin
            active_q[p] <= staged_q[p];
          end
          state_q <= S_IDLE;
          done_q  <= 1'b1;
`endif
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  for (genvar p = 0; p < N_PADS; p++) begin : g_pad
    assign gpio_inp_dis[p]     = active_q[p][0];
    assign gpio_ib_mode_sel[p] = active_q[p][1];
    assign gpio_vtrip_sel[p]   = active_q[p][2];
    assign gpio_slow_sel[p]    = active_q[p][3];
    assign gpio_holdover[p]    = active_q[p][4];
    assign gpio_analog_en[p]   = active_q[p][5];
    assign gpio_analog_sel[p]  = active_q[p][6];
    assign gpio_analog_pol[p]  = active_q[p][7];
    assign gpio_dm0[p]         = active_q[p][8];
    assign gpio_dm1[p]         = active_q[p][9];
    assign gpio_dm2[p]         = active_q[p][10];
  end

endmodule

`default_nettype wire

// File: tb/tb_tt_gpio_cfg_seq.sv
// ============================================================================
//  Module      : tb_tt_gpio_cfg_seq
//  Description : Self-checking bench for tt_gpio_cfg_seq. Holds a reference
//                staged/active bank model; each commit pushes the expected
//                active bank to a scoreboard that is popped on done.
//                Adapts expected timing to TT_GPIO_CFG_STAGGER_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tt_gpio_cfg_seq;

  localparam int          N   = 44;
  localparam int          W   = 6;
  localparam int          DIV = 4;
  localparam int          BW  = N * 11;
  localparam logic [10:0] DEF = 11'h100;
`ifdef TT_GPIO_CFG_STAGGER_EN
  localparam int          STEP = DIV;
`else
  localparam int          STEP = 0;
`endif
  localparam int          LAT = 1 + (N - 1) * STEP;

  typedef logic [BW-1:0] bank_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tt_gpio_cfg_seq_if #(.PAD_IDX_W(W)) bus ();

  logic [N-1:0] inp_dis, ib_mode, vtrip, slow, hold, an_en, an_sel, an_pol, dm0, dm1, dm2;

  tt_gpio_cfg_seq #(
    .N_PADS      (N),
    .DEFAULT_CFG (DEF),
    .STAGGER_DIV (DIV),
    .PAD_IDX_W   (W)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus),
    .gpio_inp_dis     (inp_dis),
    .gpio_ib_mode_sel (ib_mode),
    .gpio_vtrip_sel   (vtrip),
    .gpio_slow_sel    (slow),
    .gpio_holdover    (hold),
    .gpio_analog_en   (an_en),
    .gpio_analog_sel  (an_sel),
    .gpio_analog_pol  (an_pol),
    .gpio_dm0         (dm0),
    .gpio_dm1         (dm1),
    .gpio_dm2         (dm2)
  );

  int    checks = 0;
  int    errors = 0;
  bank_t staged_m;
  bank_t active_m;
  bank_t sb_q [$];
  bit    err_q [$];

  function automatic bank_t dut_out();
    bank_t v;
    for (int p = 0; p < N; p++)
      v[p*11 +: 11] = {dm2[p], dm1[p], dm0[p], an_pol[p], an_sel[p], an_en[p],
                       hold[p], slow[p], vtrip[p], ib_mode[p], inp_dis[p]};
    return v;
  endfunction

  task automatic check(input string tag, input bank_t obs, input bank_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    check(tag, bank_t'(obs), bank_t'(exp));
  endtask

  // Called at a negedge with the DUT idle; returns at the following negedge.
  task automatic do_write(input logic [W-1:0] pad, input logic [10:0] data);
    chk1("wr_ready", bus.cfg_ready, 1'b1);
    bus.cfg_valid = 1'b1;
    bus.cfg_pad   = pad;
    bus.cfg_data  = data;
    err_q.push_back(int'(pad) >= N);
    if (int'(pad) < N) staged_m[int'(pad)*11 +: 11] = data;
    @(negedge clk);
    bus.cfg_valid = 1'b0;
    chk1("cfg_err", bus.cfg_err, err_q.pop_front());
    check("out_after_wr", dut_out(), active_m);
  endtask

  task automatic do_commit(input bit same_wr, input logic [W-1:0] spad, input logic [10:0] sdata,
                           input bit hold_wr, input logic [W-1:0] hpad, input logic [10:0] hdata,
                           input bit second);
    bank_t old_b, snap, exp;
    int    cycles;
    bus.commit = 1'b1;
    if (same_wr) begin
      bus.cfg_valid = 1'b1;
      bus.cfg_pad   = spad;
      bus.cfg_data  = sdata;
      staged_m[int'(spad)*11 +: 11] = sdata;
    end
    @(negedge clk);
    bus.commit    = second;
    bus.cfg_valid = 1'b0;
    snap  = staged_m;
    old_b = active_m;
    sb_q.push_back(staged_m);
    chk1("busy_start", bus.busy, 1'b1);
    chk1("ready_start", bus.cfg_ready, 1'b0);
    if (hold_wr) begin
      bus.cfg_valid = 1'b1;
      bus.cfg_pad   = hpad;
      bus.cfg_data  = hdata;
    end
    cycles = 0;
    while (cycles < LAT + 20) begin
      @(negedge clk);
      cycles++;
      bus.commit = 1'b0;
      exp = old_b;
      for (int k = 0; k < N; k++)
        if (cycles >= 1 + k * STEP) exp[k*11 +: 11] = snap[k*11 +: 11];
      check("apply_out", dut_out(), exp);
      if (bus.done) break;
      chk1("busy_hold", bus.busy, 1'b1);
      chk1("ready_hold", bus.cfg_ready, 1'b0);
    end
    check("done_latency", bank_t'(cycles), bank_t'(LAT));
    chk1("busy_end", bus.busy, 1'b0);
    chk1("ready_end", bus.cfg_ready, 1'b1);
    active_m = sb_q.pop_front();
    check("committed_bank", dut_out(), active_m);
    if (hold_wr) staged_m[int'(hpad)*11 +: 11] = hdata;
    @(negedge clk);
    bus.cfg_valid = 1'b0;
    chk1("done_pulse", bus.done, 1'b0);
    if (second) begin
      repeat (3) begin
        @(negedge clk);
        chk1("no_2nd_busy", bus.busy, 1'b0);
        chk1("no_2nd_done", bus.done, 1'b0);
      end
    end
  endtask

  initial begin
    bus.cfg_valid = 1'b0;
    bus.cfg_pad   = '0;
    bus.cfg_data  = '0;
    bus.commit    = 1'b0;
    staged_m      = {N{DEF}};
    active_m      = {N{DEF}};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out", dut_out(), {N{DEF}});
    chk1("rst_ready", bus.cfg_ready, 1'b1);
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_done", bus.done, 1'b0);
    chk1("rst_err", bus.cfg_err, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_out", dut_out(), {N{DEF}});

    // Staged write invisible until commit, then pad 5 all ones
    do_write(6'd5, 11'h7FF);
    do_commit(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    chk1("pad5_dm2", dm2[5], 1'b1);

    // Several pads, with a second commit pulsed mid-APPLY
    do_write(6'd0, 11'h600);
    do_write(6'd1, 11'h600);
    do_write(6'd43, 11'h600);
    do_commit(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);

    // Out-of-range index: dropped, one-cycle error pulse
    do_write(6'd50, 11'h7FF);
    @(negedge clk);
    chk1("err_one_cycle", bus.cfg_err, 1'b0);

    // Write held during APPLY is taken after done, applied by the next commit
    do_commit(1'b0, '0, '0, 1'b1, 6'd7, 11'h0AA, 1'b0);
    check("held_wr_not_visible", dut_out(), active_m);
    do_commit(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);

    // Write in the same cycle as commit is included
    do_commit(1'b1, 6'd2, 11'h020, 1'b0, '0, '0, 1'b0);
    chk1("pad2_analog_en", an_en[2], 1'b1);

    // Asynchronous reset in the middle of APPLY
    do_write(6'd10, 11'h7FF);
    bus.commit = 1'b1;
    @(negedge clk);
    bus.commit = 1'b0;
    chk1("mid_busy", bus.busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("arst_out", dut_out(), {N{DEF}});
    chk1("arst_ready", bus.cfg_ready, 1'b1);
    chk1("arst_busy", bus.busy, 1'b0);
    chk1("arst_done", bus.done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    staged_m = {N{DEF}};
    active_m = {N{DEF}};
    sb_q.delete();
    @(negedge clk);
    chk1("arst_idle", bus.busy, 1'b0);
    do_commit(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
